rr_arbiter_4: RTL

//   Round-robin arbiter sharing one downstream resource between 4 requesters.
//   - Registered one-hot grant plus 2-bit binary grant index: the encoded form a 4-to-2 encoder yields.
//   - Per-grant hold limit stops any one requester starving the others.
//   - Sits between request sources and the shared datapath; gnt_idx drives the datapath's source-select mux.

---
 rtl/rr_arbiter_4.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a per-grant hold limit.
// Produces a registered one-hot grant and its 2-bit binary index.
// Optional feature: define ARB_LOCK_EN to add a lock input that suppresses
// hold-limit preemption while the current holder asserts it.
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] holder;
    logic [3:0] others;
    logic [1:0] search_start;
    logic [3:0] search_mask;
    logic [1:0] cand;
    logic       win_found;
    logic [1:0] win_idx;
    logic       preempt_ok;

`ifdef ARB_LOCK_EN
    assign preempt_ok = ~lock;
`else
    assign preempt_ok = 1'b1;
`endif

    // Pick the first requester in circular order from the search start.
    // While granting, the search starts after the holder and excludes it.
    always_comb begin
        holder       = gnt_idx_q;
        others       = req & ~(4'b0001 << holder);
        search_start = (state_q == StIdle) ? ptr_q : holder + 2'd1;
        search_mask  = (state_q == StIdle) ? req : others;
        win_found    = 1'b0;
        win_idx      = search_start;
        cand         = search_start;
        for (int k = 0; k < 4; k++) begin
            cand = search_start + 2'(k);
            if (!win_found && search_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: grant, release, back-to-back handoff and preemption.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d      = 4'b0001 << win_idx;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = CntOne;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (!req[holder]) begin
                    // Release has priority over preemption; ptr update is the same.
                    ptr_d = holder + 2'd1;
                    if (win_found) begin
                        gnt_d      = 4'b0001 << win_idx;
                        gnt_idx_d  = win_idx;
                        hold_cnt_d = CntOne;
                    end else begin
                        gnt_d      = 4'b0000;
                        hold_cnt_d = '0;
                        state_d    = StIdle;
                    end
                end else if (hold_cnt_q == HoldMax && win_found && preempt_ok) begin
                    ptr_d      = holder + 2'd1;
                    gnt_d      = 4'b0001 << win_idx;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = CntOne;
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers; reset drops any active grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 4'b0000;
            gnt_idx_q  <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = |gnt_q;

endmodule
